// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding, widths and bubble control values for the pipeline hazard controller
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;
  localparam int DEF_REG_W = 5;
  typedef struct packed {
    logic [1:0] wb;
    logic [2:0] mem;
  } bubble_ctrl_t;
  // Control fields a flushed buffer loads so the slot behaves as a no-op
  localparam bubble_ctrl_t BUBBLE_CTRL = '{wb: 2'b00, mem: 3'b000};
endpackage

// File: rtl/hazard_mem_wait_fsm.sv
// hazard_mem_wait_fsm: tracks data-memory wait cycles, timing out into a sticky error state
module hazard_mem_wait_fsm
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   access,
  input  logic   dmem_ready,
  output state_t state,
  output logic   mwait,
  output logic   error
);
  logic [7:0] cnt;
  assign mwait = access & ~dmem_ready;
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
      error <= 1'b0;
    end else
      case (state)
        RUN: if (mwait) begin
          state <= MEM_WAIT;
          cnt   <= 8'd1;
        end
        MEM_WAIT:
          if (!mwait) begin
            state <= RUN;
            cnt   <= '0;
          end else if (cnt == 8'(MEM_TIMEOUT)) begin
            state <= ERROR;
            error <= 1'b1;
          end else
            cnt <= cnt + 8'd1;
        default: state <= ERROR;
      endcase
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/freeze sequencer for the 5-stage pipeline.
// Define HAZARD_PERF_EN to add saturating stall/flush/memwait performance counters.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int REG_W       = DEF_REG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             mem_branch,
  input  logic             mem_zero,
  input  logic             mem_memread,
  input  logic             mem_memwrite,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             pc_src,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             freeze,
  output logic             mem_error
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]      perf_stall_cnt,
  output logic [31:0]      perf_flush_cnt,
  output logic [31:0]      perf_memwait_cnt
`endif
);
  state_t state;
  logic   mwait, err, hold, br, st, taken, lu;
  hazard_mem_wait_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_fsm (
    .clk       (clk),
    .rst_n     (rst_n),
    .access    (mem_memread | mem_memwrite),
    .dmem_ready(dmem_ready),
    .state     (state),
    .mwait     (mwait),
    .error     (mem_error)
  );
  assign err   = state == ERROR;
  assign taken = mem_branch & mem_zero;
  assign lu    = ex_memread & (ex_rt != '0) & ((ex_rt == id_rs) | (ex_rt == id_rt));
  // Priority chain: error/wait freeze everything, then branch, then load-use
  assign hold  = err | mwait;
  assign br    = ~hold & taken;
  assign st    = ~hold & ~taken & lu;
  assign pc_write     = rst_n & ~hold & ~st;
  assign pc_src       = rst_n & br;
  assign if_id_write  = rst_n & ~hold & ~st;
  assign if_id_flush  = ~rst_n | br;
  assign id_ex_flush  = ~rst_n | br | st;
  assign ex_mem_flush = ~rst_n | br;
  assign freeze       = ~rst_n | hold;
`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk)
    if (!rst_n) begin
      perf_stall_cnt   <= '0;
      perf_flush_cnt   <= '0;
      perf_memwait_cnt <= '0;
    end else begin
      if (st && !(&perf_stall_cnt)) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (br && !(&perf_flush_cnt)) perf_flush_cnt <= perf_flush_cnt + 32'd1;
      if (hold && !(&perf_memwait_cnt)) perf_memwait_cnt <= perf_memwait_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed and randomized checks of pipeline_hazard_ctrl against a rule-level model
module tb_pipeline_hazard_ctrl;
  localparam int TO = 4;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
  logic ex_memread = 0, mem_branch = 0, mem_zero = 0, mem_memread = 0, mem_memwrite = 0, dmem_ready = 0;
  logic pc_write, pc_src, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush, freeze, mem_error;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_memwait_cnt;
`endif
  int checks = 0, errors = 0;
  int m_waits = 0;
  bit m_err = 0;
  longint m_st = 0, m_fl = 0, m_fz = 0;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .REG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .ex_memread(ex_memread), .ex_rt(ex_rt),
    .mem_branch(mem_branch), .mem_zero(mem_zero), .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .dmem_ready(dmem_ready), .pc_write(pc_write), .pc_src(pc_src), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush), .freeze(freeze),
    .mem_error(mem_error)
`ifdef HAZARD_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt), .perf_memwait_cnt(perf_memwait_cnt)
`endif
  );

  function automatic bit mw_now();
    return (mem_memread | mem_memwrite) & ~dmem_ready;
  endfunction
  function automatic bit tk_now();
    return mem_branch & mem_zero;
  endfunction
  function automatic bit lu_now();
    return ex_memread && ex_rt != 0 && (ex_rt == id_rs || ex_rt == id_rt);
  endfunction
  // Expected {pc_write,pc_src,if_id_write,if_id_flush,id_ex_flush,ex_mem_flush,freeze,mem_error}
  function automatic logic [7:0] expv();
    if (!rst_n) return {7'b000_1111, m_err};
    if (m_err) return 8'b0000_0011;
    if (mw_now()) return 8'b0000_0010;
    if (tk_now()) return 8'b1101_1100;
    if (lu_now()) return 8'b0000_1000;
    return 8'b1010_0000;
  endfunction
  // if_id_write is left unconstrained while the IF/ID buffer is being flushed
  function automatic logic [7:0] maskv();
    return (!rst_n || (!m_err && !mw_now() && tk_now())) ? 8'hDF : 8'hFF;
  endfunction
  function automatic logic [7:0] obsv();
    return {pc_write, pc_src, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush, freeze, mem_error};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      m_waits = 0; m_err = 0; m_st = 0; m_fl = 0; m_fz = 0;
    end else begin
      if (m_err || mw_now()) m_fz++;
      else if (tk_now()) m_fl++;
      else if (lu_now()) m_st++;
      if (!m_err) begin
        if (mw_now()) begin
          m_waits++;
          if (m_waits > TO) m_err = 1;
        end else m_waits = 0;
      end
    end
    #1;
  endtask

  task automatic drive(input logic [4:0] rs, rt, exrt, input bit exr, br, z, mr, mwr, rdy);
    id_rs = rs; id_rt = rt; ex_rt = exrt; ex_memread = exr;
    mem_branch = br; mem_zero = z; mem_memread = mr; mem_memwrite = mwr; dmem_ready = rdy;
  endtask

  task automatic test_reset();
    rst_n = 0;
    drive(5'd3, 5'd4, 5'd3, 1, 1, 1, 1, 0, 0);
    tick();
    @(negedge clk);
    checks++;
    if ((obsv() & maskv()) !== (expv() & maskv()))
      begin errors++; $display("FAIL reset_hold got=%b exp=%b", obsv(), expv()); end
    tick();
    rst_n = 1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (obsv() !== 8'b1010_0000) begin errors++; $display("FAIL reset_release got=%b exp=%b", obsv(), 8'b1010_0000); end
`ifdef HAZARD_PERF_EN
    checks++;
    if ({perf_stall_cnt, perf_flush_cnt, perf_memwait_cnt} !== 96'd0)
      begin errors++; $display("FAIL reset_perf got=%h/%h/%h exp=0", perf_stall_cnt, perf_flush_cnt, perf_memwait_cnt); end
`endif
    tick();
  endtask

  task automatic test_load_use();
    logic [4:0] rs_v [4] = '{5'd8, 5'd0, 5'd2, 5'd1};
    logic [4:0] rt_v [4] = '{5'd1, 5'd0, 5'd9, 5'd1};
    logic [4:0] ex_v [4] = '{5'd8, 5'd0, 5'd9, 5'd7};
    for (int i = 0; i < 4; i++) begin
      drive(rs_v[i], rt_v[i], ex_v[i], 1, 0, 0, 0, 0, 1);
      @(negedge clk);
      checks++;
      if ((obsv() & maskv()) !== (expv() & maskv()))
        begin errors++; $display("FAIL load_use_%0d got=%b exp=%b", i, obsv(), expv()); end
      tick();
      drive(rs_v[i], rt_v[i], ex_v[i], 0, 0, 0, 0, 0, 1);
      @(negedge clk);
      checks++;
      if (obsv() !== 8'b1010_0000) begin errors++; $display("FAIL load_use_next_%0d got=%b exp=%b", i, obsv(), 8'b1010_0000); end
      tick();
    end
  endtask

  task automatic test_branch();
    for (int i = 0; i < 4; i++) begin
      drive(5'd5, 5'd6, 5'd5, i[1], 1, i[0], 0, 0, 1);
      @(negedge clk);
      checks++;
      if ((obsv() & maskv()) !== (expv() & maskv()))
        begin errors++; $display("FAIL branch_%0d got=%b exp=%b", i, obsv(), expv()); end
      checks++;
      if (pc_src !== i[0]) begin errors++; $display("FAIL branch_pc_src_%0d got=%b exp=%b", i, pc_src, i[0]); end
      tick();
    end
  endtask

  task automatic test_mem_wait();
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, i < 4, 1, i < 4, 0, i >= 3);
      @(negedge clk);
      checks++;
      if ((obsv() & maskv()) !== (expv() & maskv()))
        begin errors++; $display("FAIL mem_wait_%0d got=%b exp=%b", i, obsv(), expv()); end
      checks++;
      if (freeze !== (i < 3)) begin errors++; $display("FAIL mem_wait_freeze_%0d got=%b exp=%b", i, freeze, i < 3); end
      tick();
    end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < TO + 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
      @(negedge clk);
      checks++;
      if ((obsv() & maskv()) !== (expv() & maskv()))
        begin errors++; $display("FAIL timeout_%0d got=%b exp=%b", i, obsv(), expv()); end
      tick();
    end
    drive(0, 0, 0, 0, 1, 1, 0, 0, 1);
    @(negedge clk);
    checks++;
    if (obsv() !== 8'b0000_0011) begin errors++; $display("FAIL timeout_sticky got=%b exp=%b", obsv(), 8'b0000_0011); end
    tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (obsv() !== 8'b1010_0000) begin errors++; $display("FAIL timeout_reset got=%b exp=%b", obsv(), 8'b1010_0000); end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    tick();
    rst_n = 0;
    @(negedge clk);
    checks++;
    if ((obsv() & 8'hDE) !== 8'b0001_1110) begin errors++; $display("FAIL mid_wait_forced got=%b exp=%b", obsv(), 8'b0001_1110); end
    tick();
    rst_n = 1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (obsv() !== 8'b1010_0000) begin errors++; $display("FAIL mid_wait_run got=%b exp=%b", obsv(), 8'b1010_0000); end
`ifdef HAZARD_PERF_EN
    checks++;
    if ({perf_stall_cnt, perf_flush_cnt, perf_memwait_cnt} !== 96'd0)
      begin errors++; $display("FAIL mid_wait_perf got=%h/%h/%h exp=0", perf_stall_cnt, perf_flush_cnt, perf_memwait_cnt); end
`endif
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst_n = $urandom_range(99) >= 3;
      drive(5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)), $urandom_range(1),
            $urandom_range(1), $urandom_range(1), $urandom_range(9) < 2, $urandom_range(9) < 2,
            $urandom_range(9) < 5);
      @(negedge clk);
      checks++;
      if ((obsv() & maskv()) !== (expv() & maskv()))
        begin errors++; $display("FAIL random_%0d got=%b exp=%b", i, obsv(), expv()); end
`ifdef HAZARD_PERF_EN
      checks++;
      if ({perf_stall_cnt, perf_flush_cnt, perf_memwait_cnt} !== {32'(m_st), 32'(m_fl), 32'(m_fz)})
        begin errors++; $display("FAIL random_perf_%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", i,
          perf_stall_cnt, perf_flush_cnt, perf_memwait_cnt, m_st, m_fl, m_fz); end
`endif
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
